mem_port_arbiter: RTL

- Shares the single-ported unified instruction/data memory between two requesters: the instruction-fetch stage and the load/store stage of the MIPS calculator core.
- Grants at most one memory access per cycle.
- Routes the one-cycle-latency read data back to whichever requester issued the access.
- Starvation guard: fetch is never locked out by a long run of loads/stores.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              addr_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, addr_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, addr_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-ported unified memory
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     streak;
    logic              resp_load;
    logic              resp_err;
    logic              addr_err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              if_gnt;
    logic              d_gnt;
    logic              if_oor;
    logic              d_oor;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_rvalid;
    logic              d_rvalid;
    logic [DATA_W-1:0] rd_word;

    assign if_oor = (bus.if_addr >= ADDR_W'(DEPTH));
    assign d_oor  = (bus.d_addr  >= ADDR_W'(DEPTH));

    // Data normally wins; a full streak with fetch waiting hands one slot to fetch.
    always_comb begin
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        state_next = ST_IDLE;
        if (!rst) begin
            if (bus.d_req && (!bus.if_req || streak != SW'(MAX_STREAK)))
                d_gnt = 1'b1;
            else if (bus.if_req)
                if_gnt = 1'b1;
        end
        if (d_gnt)
            state_next = ST_DATA;
        else if (if_gnt)
            state_next = ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Out-of-range accesses keep the handshake but never touch the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = !d_oor;
            mem_we    = bus.d_we && !d_oor;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            mem_en    = !if_oor;
            mem_addr  = bus.if_addr;
        end
    end

    // The registered owner doubles as the response tag; stores leave DATA without a load flag.
    assign if_rvalid = (state == ST_FETCH);
    assign d_rvalid  = (state == ST_DATA) && resp_load;
    assign rd_word   = resp_err ? '0 : bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak     <= '0;
            resp_load  <= 1'b0;
            resp_err   <= 1'b0;
            addr_err_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (!bus.if_req || if_gnt)
                streak <= '0;
            else if (d_gnt && streak != SW'(MAX_STREAK))
                streak <= streak + SW'(1);

            resp_load  <= d_gnt && !bus.d_we;
            resp_err   <= (d_gnt && d_oor) || (if_gnt && if_oor);
            addr_err_q <= (d_gnt && d_oor) || (if_gnt && if_oor);

            if (if_rvalid)
                if_rdata_q <= rd_word;
            if (d_rvalid)
                d_rdata_q <= rd_word;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? rd_word : if_rdata_q;
    assign bus.d_rdata   = d_rvalid  ? rd_word : d_rdata_q;
    assign bus.addr_err  = addr_err_q;
endmodule
